// File: rtl/wb_pkg.sv
// Shared constants and the queued-write entry type for the register-file write-back path.
package wb_pkg;
    localparam int DATA_W   = 16;
    localparam int REG_AW   = 3;
    localparam int NUM_REGS = 2 ** REG_AW;
    localparam int WB_DEPTH = 4;

    typedef struct packed {
        logic              live;
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/wb_load_fifo.sv
// In-order load-result queue with per-entry kill by destination register and busy-bit reduction.
module wb_load_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enq,
    input  logic [REG_AW-1:0]        enq_rd,
    input  logic [DATA_W-1:0]        enq_data,
    input  logic                     deq,
    input  logic                     squash,
    input  logic [REG_AW-1:0]        squash_rd,
    output wb_entry_t                head,
    output logic                     empty,
    output logic                     ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic [NUM_REGS-1:0]      busy
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

    logic [REG_AW-1:0] rd_mem   [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [DEPTH-1:0]  live;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;

    // Kill is applied before the enqueue so a same-edge load with the squashed rd stays live.
    always_ff @(posedge clk) begin
        if (rst) begin
            live   <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (squash && live[i] && rd_mem[i] == squash_rd)
                    live[i] <= 1'b0;
            end
            if (deq) begin
                live[rd_ptr] <= 1'b0;
                rd_ptr       <= rd_ptr + 1'b1;
            end
            if (enq) begin
                live[wr_ptr] <= 1'b1;
                wr_ptr       <= wr_ptr + 1'b1;
            end
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            rd_mem[wr_ptr]   <= enq_rd;
            data_mem[wr_ptr] <= enq_data;
        end
    end

    always_comb begin
        busy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live[i])
                busy[rd_mem[i]] = 1'b1;
        end
    end

    assign head  = '{live: live[rd_ptr], rd: rd_mem[rd_ptr], data: data_mem[rd_ptr]};
    assign empty = (count == '0);
    assign ready = (count < FULL_CNT);
endmodule

// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: ALU results first, then queued loads in order.
// Optional WB_BYPASS_EN lets a load skip the empty queue when the ALU is idle.
module wb_write_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   alu_valid,
    input  logic [REG_AW-1:0]      alu_rd,
    input  logic [DATA_W-1:0]      alu_data,
    input  logic                   ld_valid,
    input  logic [REG_AW-1:0]      ld_rd,
    input  logic [DATA_W-1:0]      ld_data,
    output logic                   ld_ready,
    output logic                   rf_we,
    output logic [REG_AW-1:0]      rf_rd,
    output logic [DATA_W-1:0]      rf_wdata,
    output logic [NUM_REGS-1:0]    busy,
    output logic [$clog2(DEPTH):0] fifo_count
);
    wb_entry_t head;
    logic      fifo_empty;
    logic      bypass_take;
    logic      enq;
    logic      deq;

`ifdef WB_BYPASS_EN
    assign bypass_take = ld_valid & fifo_empty & ~alu_valid;
`else
    assign bypass_take = 1'b0;
`endif

    assign enq = ld_valid & ld_ready & ~bypass_take;
    assign deq = ~alu_valid & ~fifo_empty;

    wb_load_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .enq       (enq),
        .enq_rd    (ld_rd),
        .enq_data  (ld_data),
        .deq       (deq),
        .squash    (alu_valid),
        .squash_rd (alu_rd),
        .head      (head),
        .empty     (fifo_empty),
        .ready     (ld_ready),
        .count     (fifo_count),
        .busy      (busy)
    );

    // Output register stage: a killed head consumes its slot but produces no write.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_rd    <= '0;
            rf_wdata <= '0;
        end else if (alu_valid) begin
            rf_we    <= 1'b1;
            rf_rd    <= alu_rd;
            rf_wdata <= alu_data;
        end else if (!fifo_empty) begin
            rf_we <= head.live;
            if (head.live) begin
                rf_rd    <= head.rd;
                rf_wdata <= head.data;
            end
        end else if (bypass_take) begin
            rf_we    <= 1'b1;
            rf_rd    <= ld_rd;
            rf_wdata <= ld_data;
        end else begin
            rf_we <= 1'b0;
        end
    end
endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed and randomized bench for wb_write_arbiter against a queue-based reference model.
module tb_wb_write_arbiter;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [2:0]  alu_rd;
    logic [15:0] alu_data;
    logic        ld_valid;
    logic [2:0]  ld_rd;
    logic [15:0] ld_data;
    logic        ld_ready;
    logic        rf_we;
    logic [2:0]  rf_rd;
    logic [15:0] rf_wdata;
    logic [7:0]  busy;
    logic [2:0]  fifo_count;

    always #5 clk = ~clk;

    wb_write_arbiter #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .ld_valid   (ld_valid),
        .ld_rd      (ld_rd),
        .ld_data    (ld_data),
        .ld_ready   (ld_ready),
        .rf_we      (rf_we),
        .rf_rd      (rf_rd),
        .rf_wdata   (rf_wdata),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    typedef struct {
        bit        live;
        bit [2:0]  rd;
        bit [15:0] data;
    } ent_t;

    ent_t      q[$];
    bit        m_we;
    bit [2:0]  m_rd;
    bit [15:0] m_wd;
    bit [15:0] m_regs   [8];
    bit [15:0] obs_regs [8];
    int        n_assert = 0;
    int        n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit [7:0] model_busy();
        bit [7:0] b = '0;
        foreach (q[i]) if (q[i].live) b[q[i].rd] = 1'b1;
        return b;
    endfunction

    // One clock: drive inputs, advance the model, then compare after the edge.
    task automatic step(input bit r, input bit av, input bit [2:0] ard, input bit [15:0] ad,
                        input bit lv, input bit [2:0] lrd, input bit [15:0] ld, output bit acc);
        bit   byp;
        ent_t h;
        rst = r; alu_valid = av; alu_rd = ard; alu_data = ad;
        ld_valid = lv; ld_rd = lrd; ld_data = ld;
        acc = 1'b0;
        if (r) begin
            q.delete();
            m_we = 1'b0; m_rd = '0; m_wd = '0;
        end else begin
            acc = lv && (q.size() < DEPTH);
`ifdef WB_BYPASS_EN
            byp = lv && (q.size() == 0) && !av;
`else
            byp = 1'b0;
`endif
            if (av) begin
                m_we = 1'b1; m_rd = ard; m_wd = ad;
                foreach (q[i]) if (q[i].rd == ard) q[i].live = 1'b0;
            end else if (q.size() > 0) begin
                h = q.pop_front();
                m_we = h.live;
                if (h.live) begin m_rd = h.rd; m_wd = h.data; end
            end else if (byp) begin
                m_we = 1'b1; m_rd = lrd; m_wd = ld;
            end else begin
                m_we = 1'b0;
            end
            if (acc && !byp) q.push_back('{live: 1'b1, rd: lrd, data: ld});
            if (m_we) m_regs[m_rd] = m_wd;
        end
        @(posedge clk);
        #1;
        chk("rf_we", rf_we, m_we);
        if (m_we || r) begin
            chk("rf_rd", rf_rd, m_rd);
            chk("rf_wdata", rf_wdata, m_wd);
        end
        chk("busy", busy, model_busy());
        chk("ld_ready", ld_ready, q.size() < DEPTH);
        chk("fifo_count", fifo_count, q.size());
        if (rf_we === 1'b1) obs_regs[rf_rd] = rf_wdata;
    endtask

    initial begin
        bit        acc;
        int        k;
        bit        pend;
        bit [2:0]  p_rd;
        bit [15:0] p_d;
        foreach (m_regs[i]) begin m_regs[i] = '0; obs_regs[i] = '0; end

        // 1. Reset held two cycles.
        step(1, 0, 0, 0, 0, 0, 0, acc);
        step(1, 0, 0, 0, 0, 0, 0, acc);
        chk("t1_count", fifo_count, 0);

        // 2. ALU only.
        step(0, 1, 3, 16'h1234, 0, 0, 0, acc);
        chk("t2_rd", rf_rd, 3);
        chk("t2_data", rf_wdata, 16'h1234);
        step(0, 0, 0, 0, 0, 0, 0, acc);
        chk("t2_we_off", rf_we, 0);

        // 3. ALU and load in the same cycle.
        step(0, 1, 1, 16'hAAAA, 1, 2, 16'h5555, acc);
        chk("t3_busy2", busy[2], 1);
        step(0, 0, 0, 0, 0, 0, 0, acc);
        chk("t3_r2", rf_wdata, 16'h5555);
        chk("t3_busy2_clr", busy[2], 0);
        step(0, 0, 0, 0, 0, 0, 0, acc);

        // 4. Fill the queue behind a stalling ALU; the fifth load must be held.
        k = 0;
        for (int c = 0; c < 7; c++) begin
            step(0, 1, 0, 16'h0100 + 16'(c), k < 5, 3'(k + 1), 16'hC000 + 16'(k), acc);
            if (acc) k++;
        end
        chk("t4_held", k, 4);
        chk("t4_ready_low", ld_ready, 0);
        for (int c = 0; c < 10; c++) begin
            step(0, 0, 0, 0, k < 5, 3'(k + 1), 16'hC000 + 16'(k), acc);
            if (acc) k++;
        end
        chk("t4_all_in", k, 5);
        chk("t4_r5", obs_regs[5], 16'hC004);

        // 5. Squash a queued load by a younger ALU write to the same register.
        step(0, 1, 0, 16'h0000, 1, 5, 16'h00FF, acc);
        step(0, 1, 5, 16'h0007, 0, 0, 0, acc);
        chk("t5_busy5", busy[5], 0);
        step(0, 0, 0, 0, 0, 0, 0, acc);
        chk("t5_killed_we", rf_we, 0);
        step(0, 0, 0, 0, 0, 0, 0, acc);
        chk("t5_r5", obs_regs[5], 16'h0007);

        // 6. Reset while entries are queued.
        for (int c = 0; c < 3; c++) step(0, 1, 7, 16'h7000, 1, 3'(c + 1), 16'hD000 + 16'(c), acc);
        step(1, 0, 0, 0, 0, 0, 0, acc);
        chk("t6_count", fifo_count, 0);
        chk("t6_busy", busy, 0);
        chk("t6_we", rf_we, 0);
        for (int c = 0; c < 4; c++) step(0, 0, 0, 0, 0, 0, 0, acc);

        // Randomized traffic with held load offers and occasional reset.
        pend = 1'b0; p_rd = '0; p_d = '0;
        for (int c = 0; c < 400; c++) begin
            if (!pend && $urandom_range(0, 99) < 55) begin
                pend = 1'b1;
                p_rd = 3'($urandom_range(0, 3));
                p_d  = 16'($urandom);
            end
            step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 45, 3'($urandom_range(0, 3)),
                 16'($urandom), pend, p_rd, p_d, acc);
            if (acc || rst) pend = 1'b0;
        end
        for (int c = 0; c < 8; c++) step(0, 0, 0, 0, 0, 0, 0, acc);
        for (int i = 0; i < 8; i++) chk("final_reg", obs_regs[i], m_regs[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
